// File: rtl/ast_width_reducer_pkg.sv
// ============================================================================
// Package : ast_wr_package
// Brief   : Shared types, derived constants and beat-count helpers for the
//           Avalon-ST width down-converter.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package ast_wr_package;

  // Default configuration: 256-bit sink, 64-bit source
  localparam int unsigned DATA_IN_W_DEF  = 256;
  localparam int unsigned DATA_OUT_W_DEF = 64;
  localparam int unsigned IN_BYTES       = DATA_IN_W_DEF / 8;
  localparam int unsigned OUT_BYTES      = DATA_OUT_W_DEF / 8;
  localparam int unsigned RATIO          = IN_BYTES / OUT_BYTES;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] nbeats;
    logic [31:0] last_empty;
  } beat_info_t;

  // Valid bytes in a word; an out-of-range empty still leaves one byte so
  // the word always produces at least one beat.
  function automatic int unsigned valid_bytes(input int unsigned in_bytes,
                                              input int unsigned empty);
    if (empty >= in_bytes) begin
      return 1;
    end
    return in_bytes - empty;
  endfunction

  // Number of narrow beats needed to carry the valid bytes of one word
  function automatic int unsigned calc_nbeats(input int unsigned in_bytes,
                                              input int unsigned out_bytes,
                                              input int unsigned empty);
    return (valid_bytes(in_bytes, empty) + out_bytes - 1) / out_bytes;
  endfunction

  // Unused trailing bytes on the final narrow beat of a word
  function automatic int unsigned calc_last_empty(input int unsigned in_bytes,
                                                  input int unsigned out_bytes,
                                                  input int unsigned empty);
    return calc_nbeats(in_bytes, out_bytes, empty) * out_bytes
           - valid_bytes(in_bytes, empty);
  endfunction

  // {nbeats, last_empty} for the default configuration
  function automatic beat_info_t calc_beats(input int unsigned empty);
    beat_info_t r;
    r.nbeats     = calc_nbeats(IN_BYTES, OUT_BYTES, empty);
    r.last_empty = calc_last_empty(IN_BYTES, OUT_BYTES, empty);
    return r;
  endfunction

endpackage : ast_wr_package

`default_nettype wire

// File: rtl/ast_width_reducer.sv
// ============================================================================
// Module : ast_width_reducer
// Brief  : Avalon-ST width down-converter. Each wide sink word is emitted as
//          up to DATA_IN_W/DATA_OUT_W narrow beats, most-significant slice
//          first, with packet framing, channel and empty carried across.
//          Full backpressure on both sides, one source beat per clock.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ast_width_reducer
  import ast_wr_package::*;
#(
  parameter int DATA_IN_W   = 256,
  parameter int CHANNEL_W   = 10,
  parameter int DATA_OUT_W  = 64,
  parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W / 8) == 0) ? 1 : $clog2(DATA_IN_W / 8),
  parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) == 0) ? 1 : $clog2(DATA_OUT_W / 8)
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  // sink (wide)
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  // source (narrow)
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int unsigned c_IN_BYTES  = DATA_IN_W / 8;
  localparam int unsigned c_OUT_BYTES = DATA_OUT_W / 8;
  localparam int unsigned c_RATIO     = c_IN_BYTES / c_OUT_BYTES;
  localparam int          c_BL_W      = $clog2(c_RATIO + 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_IN_W-1:0]   r_shift;
  logic [CHANNEL_W-1:0]   r_channel;
  logic                   r_sop;
  logic                   r_eop;
  logic [c_BL_W-1:0]      r_beats_left;
  logic [EMPTY_OUT_W-1:0] r_last_empty;
  logic                   r_rdy_en;

  logic                   w_valid;
  logic                   w_last_beat;
  logic                   w_ready;
  logic                   w_in_acc;
  logic                   w_out_acc;
  logic                   w_eop;
  logic [31:0]            w_empty_in;
  logic [c_BL_W-1:0]      w_nbeats;
  logic [EMPTY_OUT_W-1:0] w_last_empty;

  assign w_valid     = (r_state == SEND);
  assign w_last_beat = (r_beats_left == c_BL_W'(1));

  // Sink may take a new word when nothing is pending, or when the final beat
  // of the current word leaves this cycle, so words stream without bubbles.
  // r_rdy_en holds ready low until the first clock edge after reset release.
  assign w_ready   = r_rdy_en & (~w_valid | (ast_ready_i & w_last_beat));
  assign w_in_acc  = ast_valid_i & w_ready;
  assign w_out_acc = w_valid & ast_ready_i;

  // Empty only has meaning on the end-of-packet word
  assign w_empty_in   = ast_endofpacket_i ? 32'(ast_empty_i) : 32'd0;
  assign w_nbeats     = c_BL_W'(calc_nbeats(c_IN_BYTES, c_OUT_BYTES, w_empty_in));
  assign w_last_empty = EMPTY_OUT_W'(calc_last_empty(c_IN_BYTES, c_OUT_BYTES, w_empty_in));

  // State register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: leave SEND only when the last beat goes out with no reload
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_in_acc) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_out_acc && w_last_beat && !w_in_acc) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word hold / shift register, beat counter and per-word flags
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_shift      <= '0;
      r_channel    <= '0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_beats_left <= '0;
      r_last_empty <= '0;
      r_rdy_en     <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_in_acc) begin
        r_shift      <= ast_data_i;
        r_channel    <= ast_channel_i;
        r_sop        <= ast_startofpacket_i;
        r_eop        <= ast_endofpacket_i;
        r_beats_left <= w_nbeats;
        r_last_empty <= w_last_empty;
      end else if (w_out_acc) begin
        r_shift      <= r_shift << DATA_OUT_W;
        r_beats_left <= r_beats_left - c_BL_W'(1);
        r_sop        <= 1'b0;
      end
    end
  end

  assign w_eop = w_valid & r_eop & w_last_beat;

  assign ast_ready_o         = w_ready;
  assign ast_valid_o         = w_valid;
  assign ast_data_o          = r_shift[DATA_IN_W-1 -: DATA_OUT_W];
  assign ast_startofpacket_o = w_valid & r_sop;
  assign ast_endofpacket_o   = w_eop;
  assign ast_empty_o         = w_eop ? r_last_empty : '0;
  assign ast_channel_o       = r_channel;

endmodule : ast_width_reducer

`default_nettype wire

// File: tb/tb_ast_width_reducer.sv
// ============================================================================
// Module : tb_ast_width_reducer
// Brief  : Self-checking bench for ast_width_reducer (256 -> 64 bits).
//          A reference model expands every accepted sink word into its
//          expected narrow beats; the source side is compared every cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ast_width_reducer;

  logic         clk_i = 1'b0;
  logic         arst_ni;
  logic [255:0] ast_data_i;
  logic         ast_startofpacket_i;
  logic         ast_endofpacket_i;
  logic         ast_valid_i;
  logic [4:0]   ast_empty_i;
  logic [9:0]   ast_channel_i;
  logic         ast_ready_o;
  logic [63:0]  ast_data_o;
  logic         ast_startofpacket_o;
  logic         ast_endofpacket_o;
  logic         ast_valid_o;
  logic [2:0]   ast_empty_o;
  logic [9:0]   ast_channel_o;
  logic         ast_ready_i;

  ast_width_reducer #(
    .DATA_IN_W  (256),
    .CHANNEL_W  (10),
    .DATA_OUT_W (64)
  ) dut (
    .clk_i               (clk_i),
    .arst_ni             (arst_ni),
    .ast_data_i          (ast_data_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_valid_i         (ast_valid_i),
    .ast_empty_i         (ast_empty_i),
    .ast_channel_i       (ast_channel_i),
    .ast_ready_o         (ast_ready_o),
    .ast_data_o          (ast_data_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_valid_o         (ast_valid_o),
    .ast_empty_o         (ast_empty_o),
    .ast_channel_o       (ast_channel_o),
    .ast_ready_i         (ast_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  emp;
    logic [9:0]  ch;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_beats = 0;
  int          sop_cyc = 0;
  int          eop_cyc = 0;
  int          last_emp = 0;
  bit          tb_rdy_up = 0;
  bit          rnd_rdy = 0;
  int unsigned rem;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a word carries 32 - empty valid bytes (empty only on eop),
  // sent 8 bytes per beat, first byte in the MSBs.
  task automatic push_word(input logic [255:0] d, input logic s, input logic e,
                           input logic [4:0] em, input logic [9:0] ch);
    int    vb;
    int    nb;
    beat_t b;
    logic [255:0] t;
    vb = 32 - (e ? int'(em) : 0);
    nb = (vb + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      t     = d << (64 * k);
      b.d   = t[255:192];
      b.sop = s && (k == 0);
      b.eop = e && (k == nb - 1);
      b.emp = b.eop ? 3'(nb * 8 - vb) : 3'd0;
      b.ch  = ch;
      exp_q.push_back(b);
    end
  endtask

  // Sink ready may only come up on a clock edge after reset release
  always @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) tb_rdy_up = 0;
    else          tb_rdy_up = 1;
  end

  // Reset discards whatever word was in flight
  always @(negedge arst_ni) exp_q.delete();

  // Source-side monitor against the reference queue
  always @(negedge clk_i) begin
    cyc++;
    if (arst_ni) begin
      rem = exp_q.size();
      check("valid_o", 64'(ast_valid_o), 64'(rem != 0));
      check("ready_o", 64'(ast_ready_o),
            64'(tb_rdy_up && (rem == 0 || (ast_ready_i && rem == 1))));
      if (ast_valid_o && rem != 0) begin
        check("data_o", ast_data_o, exp_q[0].d);
        check("ctrl_o",
              64'({ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}),
              64'({exp_q[0].sop, exp_q[0].eop, exp_q[0].emp, exp_q[0].ch}));
        if (ast_ready_i) begin
          n_beats++;
          if (exp_q[0].sop) sop_cyc = cyc;
          if (exp_q[0].eop) begin
            eop_cyc  = cyc;
            last_emp = int'(exp_q[0].emp);
          end
          void'(exp_q.pop_front());
        end
      end
      if (ast_valid_i && ast_ready_o)
        push_word(ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_empty_i, ast_channel_i);
    end
  end

  // Random source backpressure
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rnd_rdy) ast_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Present one word and hold it until accepted; returns 1 ns after the edge
  task automatic drive_word(input logic [255:0] d, input logic s, input logic e,
                            input logic [4:0] em, input logic [9:0] ch);
    bit acc;
    acc = 0;
    ast_data_i          = d;
    ast_startofpacket_i = s;
    ast_endofpacket_i   = e;
    ast_empty_i         = em;
    ast_channel_i       = ch;
    ast_valid_i         = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_i);
      acc = ast_ready_o;
      @(posedge clk_i);
      #1;
    end
    if (!acc) check("drive_timeout", 64'd0, 64'd1);
    ast_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (exp_q.size() != 0 || ast_valid_o); i++) begin
      @(posedge clk_i);
      #1;
    end
    check("drain_timeout", 64'(exp_q.size() != 0 || ast_valid_o), 64'd0);
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom();
    return w;
  endfunction

  logic [255:0] word;
  int           nb0;
  int unsigned  nw;
  int unsigned  gap;
  logic [9:0]   pch;

  initial begin
    arst_ni             = 1'b0;
    ast_data_i          = '0;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i   = 1'b0;
    ast_valid_i         = 1'b0;
    ast_empty_i         = '0;
    ast_channel_i       = '0;
    ast_ready_i         = 1'b1;

    // Reset state
    @(negedge clk_i);
    check("rst_valid", 64'(ast_valid_o), 64'd0);
    check("rst_ready", 64'(ast_ready_o), 64'd0);
    check("rst_data", ast_data_o, 64'd0);
    check("rst_ctrl", 64'({ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}), 64'd0);
    @(posedge clk_i);
    #2 arst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 1: single-word packet, bytes 00..1F, no empty
    for (int i = 0; i < 32; i++) word[255 - 8*i -: 8] = 8'(i);
    nb0 = n_beats;
    drive_word(word, 1'b1, 1'b1, 5'd0, 10'h155);
    check("t1_beat0_data", ast_data_o, 64'h0001020304050607);
    check("t1_beat0_sop", 64'(ast_startofpacket_o), 64'd1);
    drain();
    check("t1_beats", 64'(n_beats - nb0), 64'd4);
    check("t1_empty", 64'(last_emp), 64'd0);

    // 2: 19 valid bytes -> 3 beats, empty 5 on the last
    nb0 = n_beats;
    drive_word(rand_word(), 1'b1, 1'b1, 5'd13, 10'h0F0);
    drain();
    check("t2_beats", 64'(n_beats - nb0), 64'd3);
    check("t2_empty", 64'(last_emp), 64'd5);

    // 3: 1 valid byte -> sop and eop on the same beat, empty 7
    word = rand_word();
    word[255:248] = 8'hA5;
    nb0 = n_beats;
    drive_word(word, 1'b1, 1'b1, 5'd31, 10'h3C3);
    check("t3_sop_eop", 64'({ast_startofpacket_o, ast_endofpacket_o}), 64'b11);
    check("t3_empty", 64'(ast_empty_o), 64'd7);
    check("t3_byte0", 64'(ast_data_o[63:56]), 64'hA5);
    drain();
    check("t3_beats", 64'(n_beats - nb0), 64'd1);

    // 4: 3-word packet streamed with valid held -> 12 back-to-back beats
    nb0 = n_beats;
    drive_word(rand_word(), 1'b1, 1'b0, 5'd9,  10'h2A5);
    drive_word(rand_word(), 1'b0, 1'b0, 5'd17, 10'h2A5);
    drive_word(rand_word(), 1'b0, 1'b1, 5'd0,  10'h2A5);
    drain();
    check("t4_beats", 64'(n_beats - nb0), 64'd12);
    check("t4_no_bubble", 64'(eop_cyc - sop_cyc), 64'd11);

    // 5: random packets under random backpressure
    rnd_rdy = 1;
    for (int p = 0; p < 100; p++) begin
      nw  = $urandom_range(1, 4);
      pch = 10'($urandom());
      for (int w = 0; w < int'(nw); w++) begin
        drive_word(rand_word(), w == 0, w == int'(nw) - 1, 5'($urandom()), pch);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk_i);
          #1;
        end
      end
    end
    rnd_rdy = 0;
    @(posedge clk_i);
    #2 ast_ready_i = 1'b1;
    drain();

    // 6: asynchronous reset in the middle of a 4-beat word
    drive_word(rand_word(), 1'b1, 1'b1, 5'd0, 10'h011);
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    #1 arst_ni = 1'b0;
    #1;
    check("t6_rst_valid", 64'(ast_valid_o), 64'd0);
    check("t6_rst_ready", 64'(ast_ready_o), 64'd0);
    check("t6_rst_data", ast_data_o, 64'd0);
    nb0 = n_beats;
    @(posedge clk_i);
    @(posedge clk_i);
    #2 arst_ni = 1'b1;
    @(negedge clk_i);
    check("t6_ready_pre_edge", 64'(ast_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    check("t6_ready_post_edge", 64'(ast_ready_o), 64'd1);
    check("t6_no_beats", 64'(n_beats - nb0), 64'd0);
    for (int i = 0; i < 32; i++) word[255 - 8*i -: 8] = 8'(8'h40 + i);
    drive_word(word, 1'b1, 1'b1, 5'd0, 10'h2AA);
    check("t6_beat0_data", ast_data_o, 64'h4041424344454647);
    check("t6_beat0_sop", 64'(ast_startofpacket_o), 64'd1);
    drain();
    check("t6_beats", 64'(n_beats - nb0), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ast_width_reducer

`default_nettype wire
